// File: rtl/add_sub_accum.sv
// Group accumulator for the add/sub result stream: sums up to COUNT beats (or until in_last)
// and presents the sum on a valid/ready port. Define ADD_SUB_ACCUM_SIGNED_EN for two's-complement inputs.
module add_sub_accum #(
   parameter int WIDTH     = 32,
   parameter int COUNT     = 4,
   parameter int ACC_WIDTH = WIDTH + $clog2(COUNT)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   input  logic                         in_last,
   output logic                         in_ready,
   output logic [ACC_WIDTH-1:0]         out_data,
   output logic [$clog2(COUNT+1)-1:0]   out_count,
   output logic                         out_valid,
   input  logic                         out_ready
);

   localparam int CNT_WIDTH = $clog2(COUNT + 1);
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(COUNT - 1);

   typedef enum logic {
      ACCUM,
      DONE
   } state_t;

   state_t                 state, state_nxt;
   logic [ACC_WIDTH-1:0]   acc, acc_nxt;
   logic [ACC_WIDTH-1:0]   in_ext;
   logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;

`ifdef ADD_SUB_ACCUM_SIGNED_EN
   assign in_ext = {{(ACC_WIDTH - WIDTH){in_data[WIDTH-1]}}, in_data};
`else
   assign in_ext = {{(ACC_WIDTH - WIDTH){1'b0}}, in_data};
`endif

   // NOTE: every output of this block gets a default first so no path leaves a latch.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_nxt = acc + in_ext;
               cnt_nxt = cnt + CNT_WIDTH'(1);
               if (in_last || cnt == LAST_CNT) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               acc_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = ACCUM;
            end
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACCUM;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Held in DONE because acc/cnt only change on an accept or a transfer.
   assign out_data  = acc;
   assign out_count = cnt;

endmodule

// File: tb/tb_add_sub_accum.sv
// Scoreboard bench for add_sub_accum: directed test-plan groups plus randomized groups checked
// against an arithmetic group-sum model; the monitor compares each transferred group.
module tb_add_sub_accum;

   localparam int W  = 8;
   localparam int C  = 4;
   localparam int AW = W + $clog2(C);
   localparam int CW = $clog2(C + 1);

   logic          clk;
   logic          rst;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [AW-1:0] out_data;
   logic [CW-1:0] out_count;
   logic          out_valid;
   logic          out_ready;

   typedef struct packed {
      logic [AW-1:0] sum;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   grp_sum;
   int   grp_cnt;
   int   n_checks;
   int   n_fail;

   add_sub_accum #(.WIDTH(W), .COUNT(C)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // A group is the plain integer sum of its beats, reduced modulo 2^AW when it closes.
   task automatic model_accept(input logic [W-1:0] d, input logic last);
      int   v;
      exp_t e;
`ifdef ADD_SUB_ACCUM_SIGNED_EN
      v = $signed(d);
`else
      v = d;
`endif
      grp_sum += v;
      grp_cnt++;
      if (last || grp_cnt == C) begin
         e.sum = grp_sum[AW-1:0];
         e.cnt = grp_cnt[CW-1:0];
         exp_q.push_back(e);
         grp_sum = 0;
         grp_cnt = 0;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [W-1:0] d, input logic last, output int waits);
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      waits    = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         waits++;
         if (in_ready) begin
            model_accept(d, last);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
         end
      end
      check("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send1(input logic [W-1:0] d, input logic last);
      int w;
      send(d, last, w);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_group", 32'(out_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("group_sum", 32'(out_data), 32'(e.sum));
            check("group_count", 32'(out_count), 32'(e.cnt));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int            waits;
      int            len;
      logic [AW-1:0] held_d;
      logic [CW-1:0] held_c;
      logic          last;

      n_checks  = 0;
      n_fail    = 0;
      grp_sum   = 0;
      grp_cnt   = 0;
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Full group of 8'hFF: out_valid the cycle after the 4th accept, in_ready back one cycle later.
      for (int i = 0; i < C; i++) send1(8'hFF, 1'b0);
      check("full_out_valid", 32'(out_valid), 32'd1);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_count", 32'(out_count), 32'd4);
`ifndef ADD_SUB_ACCUM_SIGNED_EN
      check("full_out_data", 32'(out_data), 32'd1020);
`endif
      @(posedge clk);
      #1;
      check("full_ready_again", 32'(in_ready), 32'd1);
      check("full_valid_drop", 32'(out_valid), 32'd0);

`ifdef ADD_SUB_ACCUM_SIGNED_EN
      send1(8'hFF, 1'b0);
      send1(8'hFF, 1'b0);
      send1(8'h7F, 1'b0);
      send1(8'h01, 1'b0);
      check("signed_out_data", 32'(out_data), 32'h07E);
      check("signed_out_count", 32'(out_count), 32'd4);
      @(posedge clk);
      #1;
`endif

      // Early termination, then a fresh group starting from zero.
      send1(8'd5, 1'b0);
      send1(8'd9, 1'b1);
      check("early_out_data", 32'(out_data), 32'd14);
      check("early_out_count", 32'(out_count), 32'd2);
      @(posedge clk);
      #1;
      for (int i = 0; i < C; i++) send1(8'd1, 1'b0);
      check("restart_out_data", 32'(out_data), 32'd4);
      @(posedge clk);
      #1;

      // Backpressure: DONE holds while in_valid is presented and ignored.
      out_ready = 1'b0;
      send1(8'd10, 1'b0);
      send1(8'd20, 1'b0);
      send1(8'd30, 1'b0);
      send1(8'd40, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'd3;
      in_last  = 1'b0;
      held_d   = out_data;
      held_c   = out_count;
      check("bp_out_data", 32'(out_data), 32'd100);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_data_stable", 32'(out_data), 32'(held_d));
         check("bp_count_stable", 32'(out_count), 32'(held_c));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(8'd3, 1'b0, waits);
      check("bp_first_accept_delay", 32'(waits), 32'd2);
      for (int i = 0; i < C - 1; i++) send1(8'd3, 1'b0);
      check("bp_next_group", 32'(out_data), 32'd12);
      @(posedge clk);
      #1;

      // Asynchronous reset between edges discards the partial group.
      send1(8'd7, 1'b0);
      send1(8'd7, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_data", 32'(out_data), 32'd0);
      grp_sum = 0;
      grp_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 1; i <= C; i++) send1(W'(i), 1'b0);
      check("arst_next_sum", 32'(out_data), 32'd10);
      @(posedge clk);
      #1;

      // Bubbles between beats carry junk data and a stray in_last that must be ignored.
      for (int i = 0; i < C; i++) begin
         send1(8'd2, 1'b0);
         in_valid = 1'b0;
         in_last  = 1'b1;
         in_data  = 8'hAA;
         @(posedge clk);
         #1;
         in_last  = 1'b0;
      end

      // Randomized groups with random bubbles and random output backpressure.
      for (int g = 0; g < 40; g++) begin
         len = $urandom_range(1, C);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 2) == 0) begin
               in_valid = 1'b0;
               in_last  = 1'($urandom_range(0, 1));
               in_data  = W'($urandom);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b0;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
            last = (b == len - 1) && ((len < C) || ($urandom_range(0, 1) == 1));
            send1(W'($urandom), last);
         end
      end

      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/add_sub_accum.md
# add_sub_accum

Downstream consumer of the registered add/sub datapath output. Accepts a stream of WIDTH-bit add/sub results over a valid/ready handshake. Sums COUNT results, or fewer if the source terminates the group early with `in_last`, into a widened accumulator. Presents each group sum on a valid/ready output port.

## Interface
- `WIDTH`, 32, width of each incoming add/sub result.
- `COUNT`, 4, maximum results per group; legal range ≥ 2.
- `ACC_WIDTH`, `WIDTH+$clog2(COUNT)`, accumulator/output width; must be ≥ default (no overflow possible at default).
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `in_data`  input  WIDTH  add/sub result.
- `in_valid`  input  1  `in_data` valid.
- `in_last`  input  1  qualified by `in_valid`; closes the current group after this beat.
- `in_ready`  output  1  block can accept a beat.
- `out_data`  output  ACC_WIDTH  group sum.
- `out_count`  output  `$clog2(COUNT+1)`  number of beats in the group (1..COUNT).
- `out_valid`  output  1  `out_data`/`out_count` valid.
- `out_ready`  input  1  consumer accepts output.

## Operation
- Accept: `in_valid && in_ready`. Transfer: `out_valid && out_ready`.
- FSM states: ACCUM and DONE. Reset state is ACCUM.
- **ACCUM:**
  - `in_ready=1`, `out_valid=0`.
  - On accept: `acc <= acc + ext(in_data)` and `cnt <= cnt+1`.
  - If the accepted beat has `in_last=1`, or `cnt==COUNT-1`, go to DONE.
- **DONE:**
  - `in_ready=0`, `out_valid=1`, `out_data=acc`, `out_count=cnt`. Outputs are held stable until transfer.
  - On transfer: `acc<=0`, `cnt<=0`, go to ACCUM.
- `ext()` zero-extends `in_data` to ACC_WIDTH by default; see Configuration.
- Arithmetic is modulo 2^ACC_WIDTH. There is no saturation and no overflow flag.
- `in_last` with `in_valid=0` is ignored.
- `in_last` on the COUNT-th beat closes the group once; it is not double-counted.
- Empty groups are impossible: every group holds ≥ 1 beat.
- `out_data` and `out_count` are don't-care while `out_valid=0`. The implementation drives them from `acc`/`cnt`.

## Timing
- **Reset values:** `in_ready=1`, `out_valid=0`, `out_data=0`, `out_count=0`. Internally `acc=0`, `cnt=0`, state=ACCUM.
- **Reset mid-group:** the partial sum is discarded and the block restarts at ACCUM on the first edge after `rst` deasserts.
- **Latency:** `out_valid` rises the cycle after the closing accept.
- `in_ready` and `out_valid` are registered-state decodes only. Neither depends combinationally on `in_valid` or `out_ready`.
- **Throughput:** one group per (beats + 1) cycles with `out_ready=1`. A full group takes COUNT+1 cycles.
- **Transfer cycle:** no beat is accepted in the transfer cycle (`in_ready=0` in DONE). The earliest next accept is the following cycle.
- **Backpressure:** with `out_ready=0`, DONE holds indefinitely and `in_valid` is ignored (not consumed).

## Configuration
- `ADD_SUB_ACCUM_SIGNED_EN`:
  - Defined: `in_data` is treated as two's complement and sign-extended to ACC_WIDTH before addition. `out_data` is a two's-complement sum.
  - Undefined: `in_data` is unsigned and zero-extended.
- All other behaviour is identical with or without the macro.

## Test plan
- WIDTH=8, COUNT=4, macro undefined: four beats of 8'hFF, `out_ready=1` -> `out_valid` the cycle after the 4th accept, `out_data=10'd1020`, `out_count=4`, then `in_ready=1` one cycle later.
- Same config with `ADD_SUB_ACCUM_SIGNED_EN`: beats 8'hFF, 8'hFF, 8'h7F, 8'h01 -> `out_data=10'h07E` (+126), `out_count=4`.
- Early termination: beats 5, 9 (`in_last=1` on the 2nd) -> `out_data=14`, `out_count=2`. The next group starts from 0: beats 1,1,1,1 -> 4.
- Backpressure: hold `out_ready=0` for 5 cycles after `out_valid` with `in_valid=1` and `in_data=3` -> `out_data`/`out_count` stable, `in_ready=0`, no beat consumed. After release, the next group's first accept occurs the cycle after transfer.
- Reset mid-group: 2 beats of 7 accepted, assert `rst` asynchronously between edges -> `in_ready=1` and `out_valid=0` immediately. After release, beats 1,2,3,4 -> `out_data=10`.
- Stall/bubble: four beats of 2 with `in_valid` toggling 1,0,1,0,... -> only valid beats counted, `out_data=8`, `out_count=4`.
